// File: rtl/uart_mem_loader.sv
// uart_mem_loader: turns demux channel writes into a load pointer, a byte FIFO, and a req/ack memory write port.
// Latency: a data byte strobed into an empty FIFO in cycle N raises mem_req in cycle N+2; one idle cycle between requests.
// Backpressure: mem_req holds until mem_ack; data bytes arriving while the FIFO is full are dropped and flag overflow.
// Optional checksum guard compiled in with `define UART_LOADER_CKSUM_GUARD_EN.
module uart_mem_loader #(
  parameter int ADDR_W     = 22,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              RESET_N,
  input  logic [7:0]        in_addr,
  input  logic [7:0]        in_data,
  input  logic              in_write,
  input  logic              in_cksum_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_req,
  input  logic              mem_ack,
  output logic              hold_reset,
  output logic              overflow,
  output logic              busy
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = ADDR_W + 8;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_REQ  = 1'b1
  } state_t;

  // FIFO storage: each entry is {target address, data byte}
  logic [ENT_W-1:0] fifo_q [FIFO_DEPTH];
  logic [ENT_W-1:0] fifo_d [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  logic [ENT_W-1:0] head_dat;

  // Loader state
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              hold_reset_q, hold_reset_d;
  logic              overflow_q, overflow_d;
  logic              guard_blk;

  // Drain side
  state_t            state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d;
  logic              busy_q, busy_d;

`ifdef UART_LOADER_CKSUM_GUARD_EN
  logic cksum_q, cksum_d;
  logic guard_q, guard_d;
  assign guard_blk = guard_q;
`else
  // Checksum flag is intentionally unused when the guard is not built.
  logic unused_cksum;
  assign unused_cksum = in_cksum_err;
  assign guard_blk    = 1'b0;
`endif

  // Full/empty always come from the registered count at the start of the cycle.
  assign fifo_full  = (cnt_q == DEPTH_C);
  assign fifo_empty = (cnt_q == '0);
  assign head_dat   = fifo_q[rd_ptr_q];

  // Channel decode: pointer shift, data push/drop, control byte, checksum guard.
  always_comb begin
    ptr_d        = ptr_q;
    hold_reset_d = hold_reset_q;
    overflow_d   = overflow_q;
    push         = 1'b0;
`ifdef UART_LOADER_CKSUM_GUARD_EN
    guard_d      = guard_q;
    cksum_d      = in_cksum_err;
`endif
    if (in_write) begin
      case (in_addr)
        8'h00: begin
          // MSB byte first; bits shifted past ADDR_W fall off the top.
          ptr_d = {ptr_q[ADDR_W-9:0], in_data};
        end
        8'h01: begin
          // While guarded, data bytes vanish without flagging overflow.
          if (!guard_blk) begin
            if (!fifo_full) begin
              push  = 1'b1;
              ptr_d = ptr_q + ADDR_W'(1);
            end else begin
              overflow_d = 1'b1;
            end
          end
        end
        8'h02: begin
          hold_reset_d = in_data[0];
          if (in_data[7]) begin
            overflow_d = 1'b0;
`ifdef UART_LOADER_CKSUM_GUARD_EN
            guard_d    = 1'b0;
`endif
          end
        end
        default: begin
        end
      endcase
    end
`ifdef UART_LOADER_CKSUM_GUARD_EN
    // A fresh checksum error wins over a same-cycle control write.
    if (in_cksum_err && !cksum_q) begin
      hold_reset_d = 1'b1;
      guard_d      = 1'b1;
    end
`endif
  end

  // FIFO next state: write at tail on push, advance head on pop, track count.
  always_comb begin
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) begin
      fifo_d[wr_ptr_q] = {ptr_q, in_data};
      wr_ptr_d         = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Drain FSM: present the head entry, hold it until acked, then pop and idle a cycle.
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    pop         = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          mem_addr_d  = head_dat[ENT_W-1:8];
          mem_wdata_d = head_dat[7:0];
          mem_req_d   = 1'b1;
          state_d     = S_REQ;
        end
      end
      S_REQ: begin
        if (mem_ack) begin
          pop       = 1'b1;
          mem_req_d = 1'b0;
          state_d   = S_IDLE;
        end
      end
      default: begin
        mem_req_d = 1'b0;
        state_d   = S_IDLE;
      end
    endcase
    busy_d = (cnt_d != '0) | mem_req_d;
  end

  // Loader, FIFO and drain registers.
  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_q[i] <= '0;
      end
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      ptr_q        <= '0;
      hold_reset_q <= 1'b0;
      overflow_q   <= 1'b0;
      state_q      <= S_IDLE;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      busy_q       <= 1'b0;
    end else begin
      fifo_q       <= fifo_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
      ptr_q        <= ptr_d;
      hold_reset_q <= hold_reset_d;
      overflow_q   <= overflow_d;
      state_q      <= state_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      busy_q       <= busy_d;
    end
  end

`ifdef UART_LOADER_CKSUM_GUARD_EN
  // Checksum edge detector and guard flag.
  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      cksum_q <= 1'b0;
      guard_q <= 1'b0;
    end else begin
      cksum_q <= cksum_d;
      guard_q <= guard_d;
    end
  end
`endif

  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_req    = mem_req_q;
  assign hold_reset = hold_reset_q;
  assign overflow   = overflow_q;
  assign busy       = busy_q;

endmodule

// File: doc/uart_mem_loader.md
Name: uart_mem_loader

Overview:
- Sits directly downstream of the UART packet demux.
- Consumes its addr/data/write byte stream and interprets the 8-bit addr as a channel number.
- Builds a load pointer, buffers data bytes with their target address in a small FIFO, and drains them to a memory port over a req/ack handshake.
- Used to download PRG/CHR images into external memory and to hold the console in reset during the download.

Parameters:
- ADDR_W, 22, width of load pointer and mem_addr; legal range 9..32.
- FIFO_DEPTH, 4, FIFO entries; power of two, at least 2; each entry is {ADDR_W addr, 8 data}.

Ports:
- clk  in  1  system clock.
- RESET_N  in  1  asynchronous active-low reset.
- in_addr  in  8  channel number from demux.
- in_data  in  8  payload byte from demux.
- in_write  in  1  one-cycle strobe; in_addr/in_data valid in that cycle.
- in_cksum_err  in  1  sticky checksum-error flag from demux.
- mem_addr  out  ADDR_W  memory write address.
- mem_wdata  out  8  memory write data.
- mem_req  out  1  write request.
- mem_ack  in  1  memory accepted the request in this cycle.
- hold_reset  out  1  hold console core in reset.
- overflow  out  1  sticky: a data byte was dropped because the FIFO was full.
- busy  out  1  FIFO non-empty or mem_req high.

Behaviour:
- Reset (async assert, sync deassert): ptr=0, FIFO empty, mem_req=0, mem_addr=0, mem_wdata=0, hold_reset=0, overflow=0, busy=0. All outputs are registered.
- Channel decode applies only in cycles where in_write=1:
  - 0x00 (pointer byte): ptr <= {ptr[ADDR_W-9:0], in_data}, shifting left by 8, MSB byte first. Three writes load a 24-bit value; bits above ADDR_W are discarded.
  - 0x01 (data byte): if FIFO count < FIFO_DEPTH, push {ptr, in_data} and ptr <= ptr+1, wrapping modulo 2^ADDR_W. Otherwise drop the byte, leave ptr unchanged, and set overflow=1.
  - 0x02 (control): hold_reset <= in_data[0]. If in_data[7]=1, clear overflow. in_data[6:1] ignored.
  - Any other channel: ignored, no state change.
- Full check uses the registered count at the start of the cycle. A push while full is dropped even if a pop happens in the same cycle.
- A pointer write does not alter entries already queued.
- Drain FSM:
  - IDLE: if FIFO non-empty, load mem_addr/mem_wdata from the FIFO head, set mem_req=1, go to REQ.
  - REQ: mem_req, mem_addr and mem_wdata stay stable until mem_ack=1 is sampled. On that edge: pop the head, mem_req=0, return to IDLE.
  - Consequence: at least one idle cycle between requests.
  - mem_ack while in IDLE is ignored.
- Latency: a data byte written into an empty FIFO in cycle N gives mem_req=1 in cycle N+2 (N+1: entry visible; N+2: registered req).
- Push and pop in the same cycle: count unchanged, both take effect.
- Reset mid-transfer: mem_req drops immediately and queued bytes are lost. The memory side must tolerate an abandoned request.
- busy = (count != 0) | mem_req, registered.
- in_cksum_err has no effect unless the optional feature is compiled in.

Optional Feature:
- Macro: UART_LOADER_CKSUM_GUARD_EN.
- Defined:
  - A 0->1 edge of in_cksum_err (detected with a registered copy) forces hold_reset=1 and sets an internal guard flag.
  - While the guard flag is set, channel 0x01 writes are discarded without setting overflow.
  - A channel 0x02 write with in_data[7]=1 clears the guard flag.
- Undefined: in_cksum_err is unconnected internally; no guard logic is generated.

Test Plan:
- Pointer 0x01,0x23,0x45 then data 0xAA,0xBB on ch1 with mem_ack one cycle after each req -> writes (0x012345,0xAA), (0x012346,0xBB); each req first asserts 2 cycles after its write strobe; busy=0 afterwards.
- mem_ack tied 0; six ch1 bytes 0x10..0x15 -> bytes 0x10..0x13 queued, 0x14/0x15 dropped, overflow=1. Release ack -> exactly four writes at ptr..ptr+3. ch2 with data 0x80 -> overflow=0.
- ptr=0x3FFFFF (ADDR_W=22), two data bytes -> writes to 0x3FFFFF then 0x000000.
- ch2 data 0x01 -> hold_reset=1; ch2 data 0x00 -> hold_reset=0; ch7 write -> no output change.
- Assert RESET_N low while mem_req=1 with 3 entries queued -> mem_req=0 immediately, busy=0, ptr=0; no write after release.
- With UART_LOADER_CKSUM_GUARD_EN defined: pulse in_cksum_err high -> hold_reset=1; following ch1 bytes produce no req and leave overflow=0; ch2 data 0x80 -> ch1 bytes are accepted again.
